// File: rtl/johnson_decoder_if.sv
// Sample/decode bundle between a Johnson-code source and johnson_decoder.
// The master drives the code samples and the slave returns the decoded status.
interface johnson_decoder_if #(
  parameter int unsigned N  = 6,
  parameter int unsigned IW = 4
);
  logic [N-1:0]   q_in;
  logic           valid_in;
  logic [IW-1:0]  index;
  logic [2*N-1:0] onehot;
  logic           legal;
  logic           locked;
  logic           seq_err;
  logic [7:0]     err_count;

  modport master (
    output q_in, valid_in,
    input  index, onehot, legal, locked, seq_err, err_count
  );

  modport slave (
    input  q_in, valid_in,
    output index, onehot, legal, locked, seq_err, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code checker/decoder: validates each sample, decodes it to
// an index and a one-hot vector, and tracks successor order with a lock FSM.
module johnson_decoder #(
  parameter int unsigned N        = 6,
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned IW       = 4
) (
  input  logic            clk,
  input  logic            clear,
  johnson_decoder_if.slave bus
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(2*N-1);
  localparam logic [3:0]    LOCK_RUN = 4'(LOCK_LEN);

  state_t         state;
  logic [3:0]     run;
  logic [IW-1:0]  prev;
  logic [IW-1:0]  index_r;
  logic [2*N-1:0] onehot_r;
  logic           legal_r;
  logic           locked_r;
  logic           seq_err_r;
  logic [7:0]     err_count_r;

  logic [N-1:0]   code;
  logic [N-1:0]   ncode;
  logic           is_legal;
  logic [IW:0]    pc;
  logic [IW-1:0]  dec_idx;
  logic [2*N-1:0] dec_oh;
  logic [IW-1:0]  succ;
  logic           is_succ;
  logic [7:0]     err_inc;

  // 0*1* codes satisfy c & (c+1) == 0; 1*0* codes satisfy the same on ~c.
  always_comb begin
    code     = bus.q_in;
    ncode    = ~bus.q_in;
    is_legal = ((code & (code + N'(1))) == '0) || ((ncode & (ncode + N'(1))) == '0);

    pc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pc = pc + (IW+1)'(code[i]);
    end
    dec_idx = code[N-1] ? IW'(2*N - int'(pc)) : IW'(pc);

    dec_oh = '0;
    for (int unsigned i = 0; i < 2*N; i++) begin
      dec_oh[i] = (dec_idx == IW'(i));
    end

    succ    = (prev == LAST_IDX) ? '0 : prev + IW'(1);
    is_succ = (dec_idx == succ);
    err_inc = (err_count_r == 8'hFF) ? err_count_r : err_count_r + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= UNLOCKED;
      run         <= '0;
      prev        <= '0;
      index_r     <= '0;
      onehot_r    <= '0;
      legal_r     <= 1'b0;
      locked_r    <= 1'b0;
      seq_err_r   <= 1'b0;
      err_count_r <= '0;
    end else begin
      seq_err_r <= 1'b0;
      if (bus.valid_in) begin
        legal_r <= is_legal;
        if (is_legal) begin
          index_r  <= dec_idx;
          onehot_r <= dec_oh;
          prev     <= dec_idx;
        end else begin
          onehot_r <= '0;
        end

        case (state)
          UNLOCKED: begin
            if (is_legal) begin
              state <= ACQUIRE;
              run   <= '0;
            end else begin
              err_count_r <= err_inc;
            end
          end
          ACQUIRE: begin
            if (!is_legal) begin
              state       <= UNLOCKED;
              err_count_r <= err_inc;
            end else if (is_succ) begin
              run <= run + 4'd1;
              if (run + 4'd1 == LOCK_RUN) begin
                state    <= LOCKED;
                locked_r <= 1'b1;
              end
            end else begin
              run <= '0;
            end
          end
          LOCKED: begin
            // An illegal sample and an out-of-order one both count as a single error.
            if (!(is_legal && is_succ)) begin
              state       <= UNLOCKED;
              locked_r    <= 1'b0;
              seq_err_r   <= 1'b1;
              err_count_r <= err_inc;
            end
          end
          default: begin
            state    <= UNLOCKED;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.index     = index_r;
  assign bus.onehot    = onehot_r;
  assign bus.legal     = legal_r;
  assign bus.locked    = locked_r;
  assign bus.seq_err   = seq_err_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed table-driven bench for johnson_decoder (N=6, LOCK_LEN=3, IW=4),
// plus hand sequences for error-counter saturation and a final clear.
module tb_johnson_decoder;

  logic clk;
  logic clear;
  int   total;
  int   bad;

  johnson_decoder_if #(.N(6), .IW(4)) bus ();

  johnson_decoder #(.N(6), .LOCK_LEN(3), .IW(4)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        v;
    logic [5:0]  q;
    logic [3:0]  idx;
    logic [11:0] oh;
    logic        leg;
    logic        lk;
    logic        se;
    logic [7:0]  ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic v, logic [5:0] q, logic [3:0] idx,
                              logic [11:0] oh, logic leg, logic lk, logic se, logic [7:0] ec);
    vec_t r;
    r.clr = clr; r.v = v; r.q = q; r.idx = idx; r.oh = oh;
    r.leg = leg; r.lk = lk; r.se = se; r.ec = ec;
    return r;
  endfunction

  task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  task automatic step(logic clr, logic v, logic [5:0] q);
    @(negedge clk);
    clear        = clr;
    bus.valid_in = v;
    bus.q_in     = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear        = 1'b1;
    bus.valid_in = 1'b0;
    bus.q_in     = '0;

    //            clr v  q          idx    onehot    leg lk se ec
    vecs.push_back(mk(1, 1, 6'b010101, 4'd0,  12'h000, 0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 1, 6'b111000, 4'd0,  12'h000, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000000, 4'd0,  12'h001, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000001, 4'd1,  12'h002, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000011, 4'd2,  12'h004, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000111, 4'd3,  12'h008, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b001111, 4'd4,  12'h010, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b011111, 4'd5,  12'h020, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b111111, 4'd6,  12'h040, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b111110, 4'd7,  12'h080, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b111100, 4'd8,  12'h100, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b111000, 4'd9,  12'h200, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b110000, 4'd10, 12'h400, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b100000, 4'd11, 12'h800, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000000, 4'd0,  12'h001, 1, 1, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000001, 4'd1,  12'h002, 1, 1, 0, 8'd0));
    // illegal while locked
    vecs.push_back(mk(0, 1, 6'b010101, 4'd1,  12'h000, 0, 0, 1, 8'd1));
    vecs.push_back(mk(0, 1, 6'b000000, 4'd0,  12'h001, 1, 0, 0, 8'd1));
    // non-successor in acquire resyncs
    vecs.push_back(mk(0, 1, 6'b110000, 4'd10, 12'h400, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 6'b100000, 4'd11, 12'h800, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 6'b000000, 4'd0,  12'h001, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 6'b000001, 4'd1,  12'h002, 1, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 6'b000011, 4'd2,  12'h004, 1, 1, 0, 8'd1));
    // skip while locked at index 2
    vecs.push_back(mk(0, 1, 6'b001111, 4'd4,  12'h010, 1, 0, 1, 8'd2));
    vecs.push_back(mk(0, 1, 6'b011111, 4'd5,  12'h020, 1, 0, 0, 8'd2));
    vecs.push_back(mk(0, 1, 6'b111111, 4'd6,  12'h040, 1, 0, 0, 8'd2));
    vecs.push_back(mk(0, 1, 6'b111110, 4'd7,  12'h080, 1, 0, 0, 8'd2));
    vecs.push_back(mk(0, 1, 6'b111100, 4'd8,  12'h100, 1, 1, 0, 8'd2));
    // valid_in low gaps with garbage on q_in
    vecs.push_back(mk(0, 0, 6'b010101, 4'd8,  12'h100, 1, 1, 0, 8'd2));
    vecs.push_back(mk(0, 0, 6'b000000, 4'd8,  12'h100, 1, 1, 0, 8'd2));
    vecs.push_back(mk(0, 0, 6'b101101, 4'd8,  12'h100, 1, 1, 0, 8'd2));
    vecs.push_back(mk(0, 1, 6'b111000, 4'd9,  12'h200, 1, 1, 0, 8'd2));
    vecs.push_back(mk(0, 0, 6'b000000, 4'd9,  12'h200, 1, 1, 0, 8'd2));
    vecs.push_back(mk(0, 1, 6'b110000, 4'd10, 12'h400, 1, 1, 0, 8'd2));
    // stall while locked, then stall while acquiring
    vecs.push_back(mk(0, 1, 6'b110000, 4'd10, 12'h400, 1, 0, 1, 8'd3));
    vecs.push_back(mk(0, 1, 6'b100000, 4'd11, 12'h800, 1, 0, 0, 8'd3));
    vecs.push_back(mk(0, 1, 6'b100000, 4'd11, 12'h800, 1, 0, 0, 8'd3));
    vecs.push_back(mk(0, 1, 6'b000000, 4'd0,  12'h001, 1, 0, 0, 8'd3));
    // clear during acquire
    vecs.push_back(mk(1, 1, 6'b000001, 4'd0,  12'h000, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b000001, 4'd1,  12'h002, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 1, 6'b101010, 4'd1,  12'h000, 0, 0, 0, 8'd1));
    vecs.push_back(mk(0, 1, 6'b011011, 4'd1,  12'h000, 0, 0, 0, 8'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].v, vecs[i].q);
      chk("index",     i, 32'(bus.index),     32'(vecs[i].idx));
      chk("onehot",    i, 32'(bus.onehot),    32'(vecs[i].oh));
      chk("legal",     i, 32'(bus.legal),     32'(vecs[i].leg));
      chk("locked",    i, 32'(bus.locked),    32'(vecs[i].lk));
      chk("seq_err",   i, 32'(bus.seq_err),   32'(vecs[i].se));
      chk("err_count", i, 32'(bus.err_count), 32'(vecs[i].ec));
    end

    // 300 more illegal samples in UNLOCKED: count climbs from 2 and pins at 255
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 6'b010010 : 6'b100001);
      chk("sat_count", i, 32'(bus.err_count), (3 + i > 255) ? 32'd255 : 32'(3 + i));
      chk("sat_seqerr", i, 32'(bus.seq_err), 32'd0);
    end
    chk("sat_locked", 0, 32'(bus.locked), 32'd0);
    chk("sat_legal",  0, 32'(bus.legal),  32'd0);

    step(1'b1, 1'b1, 6'b010010);
    chk("final_clear_count", 0, 32'(bus.err_count), 32'd0);
    chk("final_clear_index", 0, 32'(bus.index),     32'd0);
    chk("final_clear_onehot", 0, 32'(bus.onehot),   32'd0);
    chk("final_clear_seqerr", 0, 32'(bus.seq_err),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
